// File: rtl/uart_rx_bytes.sv
// 8N1 UART receiver that turns the host command stream into FIFO write strobes.
// Defining UART_RX_PARITY_EN adds an even-parity bit and the parity_err output.
module uart_rx_bytes #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_wr,
  input  logic       out_full,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       busy,
  output logic       parity_err
`else
  output logic       busy
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  state_t            state_r, state_nxt;
  logic [SYNC_STAGES-1:0] sync_r;
  logic              rx_s;
  logic [CW-1:0]     cnt_r, cnt_nxt;
  logic [2:0]        bitn_r, bitn_nxt;
  logic [7:0]        shreg_r, shreg_nxt;
  logic [7:0]        data_nxt;
  logic              wr_nxt, ferr_nxt, ovr_nxt, busy_nxt;
`ifdef UART_RX_PARITY_EN
  logic              par_r, par_nxt;
  logic              perr_nxt;

  function automatic logic even_par_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Metastability chain on the raw line, preset to idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      bitn_r    <= 3'd0;
      shreg_r   <= 8'h00;
      out_data  <= 8'h00;
      out_wr    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bitn_r    <= bitn_nxt;
      shreg_r   <= shreg_nxt;
      out_data  <= data_nxt;
      out_wr    <= wr_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
      busy      <= busy_nxt;
`ifdef UART_RX_PARITY_EN
      par_r      <= par_nxt;
      parity_err <= perr_nxt;
`endif
    end
  end

  // Next-state and frame decisions; all samples taken at mid-bit.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    bitn_nxt  = bitn_r;
    shreg_nxt = shreg_r;
    data_nxt  = out_data;
    wr_nxt    = 1'b0;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_r;
    perr_nxt  = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (cnt_r == CNT_HALF) begin
          state_nxt = rx_s ? S_IDLE : S_DATA;
          cnt_nxt   = '0;
          bitn_nxt  = 3'd0;
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          shreg_nxt = {rx_s, shreg_r[7:1]};
          cnt_nxt   = '0;
          bitn_nxt  = bitn_r + 3'd1;
          if (bitn_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PAR;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (cnt_r == CNT_LAST) begin
          par_nxt   = rx_s;
          cnt_nxt   = '0;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
          // Error priority: framing, then parity, then FIFO overrun.
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (!even_par_ok(shreg_r, par_r)) begin
            perr_nxt  = 1'b1;
`endif
          end else if (out_full) begin
            ovr_nxt   = 1'b1;
          end else begin
            wr_nxt    = 1'b1;
            data_nxt  = shreg_r;
          end
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_BREAK;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == S_START) || (state_nxt == S_DATA) ||
               (state_nxt == S_PAR)   || (state_nxt == S_STOP);
  end

endmodule
